// File: rtl/segasys1_coll_unit.sv
// Collision recorder for the System 1 video path. Sprite-sprite hits from the
// renderer are queued in a small FIFO and committed to a 1024x1 collision RAM
// whenever the CPU is not using the RAM port. Sprite-background hits set bits
// in a 32-bit register directly. The CPU reads any bit with a two-cycle
// pipelined latency and clears bits by writing.
module segasys1_coll_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_AW     = 10
) (
  input  logic              VCLKx8,
  input  logic              RESET_N,
  input  logic              VCLKx4_EN,
  input  logic              sprcoll,
  input  logic [RAM_AW-1:0] sprcoll_ad,
  input  logic              bgcoll,
  input  logic [4:0]        bgcoll_ad,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_sel,
  input  logic [RAM_AW-1:0] cpu_ad,
  output logic [7:0]        cpu_dout,
  output logic              cpu_dval,
  output logic              init_busy,
  output logic              ovf
);

  localparam int          RAM_SIZE = 1 << RAM_AW;
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   ptr_q, ptr_d;
  logic [RAM_SIZE-1:0] ram_q;
  logic [RAM_AW-1:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0]       rdPtr_q, wrPtr_q;
  logic [PW:0]         count_q, count_d;
  logic                sprPrev_q, bgPrev_q;
  logic [31:0]         bgReg_q, bgReg_d;
  logic                summary_q, summary_d;
  logic                ovf_q;
  logic                rdVal1_q, rdBit1_q;
  logic                dval_q;
  logic [7:0]          dout_q;

  logic                isIdle, sprEdge, bgEdge, cpuPort, cpuClr;
  logic                fifoEmpty, fifoFull, pop, pushReq, push, drop;
  logic                rdBit;
  logic [RAM_AW-1:0]   headAd;

  assign isIdle    = (state_q == ST_IDLE);
  assign sprEdge   = VCLKx4_EN & sprcoll & ~sprPrev_q;
  assign bgEdge    = VCLKx4_EN & bgcoll & ~bgPrev_q;
  assign cpuPort   = cpu_req & (cpu_sel == 2'd0);
  assign cpuClr    = cpu_req & cpu_wr & isIdle;
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FULL_CNT);
  assign headAd    = fifo_q[rdPtr_q];
  assign pop       = isIdle & ~fifoEmpty & ~cpuPort;
  assign pushReq   = sprEdge & isIdle;
  assign push      = pushReq & (~fifoFull | pop);
  assign drop      = pushReq & fifoFull & ~pop;

  assign init_busy = ~isIdle;
  assign ovf       = ovf_q;
  assign cpu_dval  = dval_q;
  assign cpu_dout  = dout_q;

  // Sweep FSM: clear the RAM one address per clock, then hand the port to CPU/FIFO
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {RAM_AW{1'b1}}) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep state and pointer registers
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Collision RAM and FIFO storage; contents are defined by the sweep, not by reset
  always_ff @(posedge VCLKx8) begin
    if (!isIdle) begin
      ram_q[ptr_q] <= 1'b0;
    end else if (cpuClr && cpu_sel == 2'd0) begin
      ram_q[cpu_ad] <= 1'b0;
    end else if (pop) begin
      ram_q[headAd] <= 1'b1;
    end
    if (push) fifo_q[wrPtr_q] <= sprcoll_ad;
  end

  // FIFO occupancy follows push/pop, a simultaneous pair leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, edge-detect history and the sticky overflow flag
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      sprPrev_q <= 1'b0;
      bgPrev_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (VCLKx4_EN) begin
        sprPrev_q <= sprcoll;
        bgPrev_q  <= bgcoll;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Background register and summary flag: a CPU clear is applied first so a same-cycle set wins
  always_comb begin
    bgReg_d   = bgReg_q;
    summary_d = summary_q;
    if (cpuClr && cpu_sel == 2'd1) bgReg_d[cpu_ad[4:0]] = 1'b0;
    if (cpuClr && cpu_sel == 2'd2) summary_d = 1'b0;
    if (bgEdge) bgReg_d[bgcoll_ad] = 1'b1;
    if (pop)    summary_d = 1'b1;
  end

  // Background register and summary flag storage
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      bgReg_q   <= '0;
      summary_q <= 1'b0;
    end else begin
      bgReg_q   <= bgReg_d;
      summary_q <= summary_d;
    end
  end

  // Read source select; everything reads as zero until the sweep has finished
  always_comb begin
    rdBit = 1'b0;
    if (isIdle) begin
      case (cpu_sel)
        2'd0:    rdBit = ram_q[cpu_ad];
        2'd1:    rdBit = bgReg_q[cpu_ad[4:0]];
        2'd2:    rdBit = summary_q;
        default: rdBit = 1'b0;
      endcase
    end
  end

  // Two-stage read pipeline so back-to-back requests give back-to-back data
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      rdVal1_q <= 1'b0;
      rdBit1_q <= 1'b0;
      dval_q   <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      rdVal1_q <= cpu_req & ~cpu_wr;
      rdBit1_q <= rdBit;
      dval_q   <= rdVal1_q;
      dout_q   <= rdVal1_q ? {7'b0, rdBit1_q} : 8'h00;
    end
  end

endmodule

// File: tb/tb_segasys1_coll_unit.sv
// Testbench for segasys1_coll_unit: directed stimulus, a behavioural model
// checked every cycle, and literal expectations on selected reads.
module tb_segasys1_coll_unit;

  logic       clk   = 1'b0;
  logic       rstN  = 1'b1;
  logic       en    = 1'b0;
  logic       spr   = 1'b0;
  logic [9:0] sprAd = '0;
  logic       bg    = 1'b0;
  logic [4:0] bgAd  = '0;
  logic       req   = 1'b0;
  logic       wr    = 1'b0;
  logic [1:0] sel   = '0;
  logic [9:0] ad    = '0;
  logic [7:0] dout;
  logic       dval, busy, ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  segasys1_coll_unit dut (
    .VCLKx8     (clk),
    .RESET_N    (rstN),
    .VCLKx4_EN  (en),
    .sprcoll    (spr),
    .sprcoll_ad (sprAd),
    .bgcoll     (bg),
    .bgcoll_ad  (bgAd),
    .cpu_req    (req),
    .cpu_wr     (wr),
    .cpu_sel    (sel),
    .cpu_ad     (ad),
    .cpu_dout   (dout),
    .cpu_dval   (dval),
    .init_busy  (busy),
    .ovf        (ovf)
  );

  // Behavioural model state: plain arrays for the stores, a queue for pending
  // collisions and a queue of reads tagged with the edge at which they appear.
  typedef struct { int due; logic [7:0] data; } rd_t;
  bit         mRam [1024];
  bit  [31:0] mBg      = '0;
  bit         mSum     = 1'b0;
  bit         mOvf     = 1'b0;
  bit         mIdle    = 1'b0;
  bit         mPrevSpr = 1'b0;
  bit         mPrevBg  = 1'b0;
  int         mSweep   = 0;
  int         edgeNo   = 0;
  logic [9:0] mFifo [$];
  rd_t        mRd [$];
  bit         mExpDval = 1'b0;
  logic [7:0] mExpDout = 8'h00;
  logic [7:0] mRdData;
  bit         mSprE, mBgE, mCpuPort, mPop;
  logic [9:0] mHead;

  // Model update at each clock edge, reset asynchronously like the design
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      foreach (mRam[i]) mRam[i] = 1'b0;
      mBg = '0; mSum = 0; mOvf = 0; mIdle = 0; mPrevSpr = 0; mPrevBg = 0;
      mSweep = 0; edgeNo = 0; mFifo.delete(); mRd.delete();
      mExpDval = 0; mExpDout = 8'h00;
    end else begin
      edgeNo++;
      mSprE = en && spr && !mPrevSpr;
      mBgE  = en && bg && !mPrevBg;
      if (en) begin mPrevSpr = spr; mPrevBg = bg; end
      mRdData = 8'h00;
      if (mIdle) begin
        if (sel == 2'd0) mRdData = {7'b0, mRam[ad]};
        if (sel == 2'd1) mRdData = {7'b0, mBg[ad[4:0]]};
        if (sel == 2'd2) mRdData = {7'b0, mSum};
      end
      if (req && !wr) mRd.push_back('{edgeNo + 1, mRdData});
      mCpuPort = req && (sel == 2'd0);
      mPop = mIdle && (mFifo.size() > 0) && !mCpuPort;
      if (mIdle && req && wr) begin
        if (sel == 2'd0) mRam[ad] = 1'b0;
        if (sel == 2'd1) mBg[ad[4:0]] = 1'b0;
        if (sel == 2'd2) mSum = 1'b0;
      end
      if (mPop) begin
        mHead = mFifo.pop_front();
        mRam[mHead] = 1'b1;
        mSum = 1'b1;
      end
      if (mBgE) mBg[bgAd] = 1'b1;
      if (mSprE && mIdle) begin
        if (mFifo.size() < 4) mFifo.push_back(sprAd);
        else mOvf = 1'b1;
      end
      if (!mIdle) begin
        mSweep++;
        if (mSweep == 1024) mIdle = 1'b1;
      end
      mExpDval = 1'b0;
      mExpDout = 8'h00;
      if (mRd.size() > 0 && mRd[0].due == edgeNo) begin
        mExpDval = 1'b1;
        mExpDout = mRd[0].data;
        void'(mRd.pop_front());
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the clock edge
  always @(negedge clk) begin
    vectors++;
    if (dval !== mExpDval || dout !== mExpDout || busy !== !mIdle || ovf !== mOvf) begin
      miscompares++;
      $display("[TB] FAIL cycle-check t=%0t dval=%b want %b dout=%h want %h busy=%b want %b ovf=%b want %b",
               $time, dval, mExpDval, dout, mExpDout, busy, !mIdle, ovf, mOvf);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the enable toggles so it is high on every other edge
  task automatic applyStimulus();
    @(posedge clk);
    #2;
    en = ~en;
  endtask

  task automatic alignEn();
    if (!en) applyStimulus();
  endtask

  task automatic doRead(input logic [1:0] s, input logic [9:0] a, input logic [7:0] exp, input string name);
    req = 1'b1; wr = 1'b0; sel = s; ad = a;
    applyStimulus();
    req = 1'b0;
    applyStimulus();
    checkOutput({name, " dval"}, {7'b0, dval}, 8'h01);
    checkOutput({name, " data"}, dout, exp);
  endtask

  task automatic doWrite(input logic [1:0] s, input logic [9:0] a);
    req = 1'b1; wr = 1'b1; sel = s; ad = a;
    applyStimulus();
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic sprPulse(input logic [9:0] a, input int ticks);
    alignEn();
    spr = 1'b1; sprAd = a;
    repeat (2 * ticks) applyStimulus();
    spr = 1'b0;
    repeat (2) applyStimulus();
  endtask

  logic [9:0] evAd [6];

  initial begin
    evAd[0] = 10'h100; evAd[1] = 10'h155; evAd[2] = 10'h0AA;
    evAd[3] = 10'h3C3; evAd[4] = 10'h201; evAd[5] = 10'h022;

    // Reset state
    #1 rstN = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("reset init_busy", {7'b0, busy}, 8'h01);
    checkOutput("reset ovf", {7'b0, ovf}, 8'h00);
    checkOutput("reset dval", {7'b0, dval}, 8'h00);
    checkOutput("reset dout", dout, 8'h00);
    rstN = 1'b1;

    // Sweep length, a read during the sweep, then every address reads zero
    doRead(2'd2, 10'h000, 8'h00, "read during init");
    repeat (1021) applyStimulus();
    checkOutput("busy at clk 1023", {7'b0, busy}, 8'h01);
    applyStimulus();
    checkOutput("busy after sweep", {7'b0, busy}, 8'h00);
    for (int i = 0; i < 1024; i++) begin
      req = 1'b1; wr = 1'b0; sel = 2'd0; ad = 10'(i);
      applyStimulus();
    end
    req = 1'b0;
    repeat (2) applyStimulus();
    doRead(2'd0, 10'h3FF, 8'h00, "ram top after sweep");

    // Held pulse counts once
    sprPulse(10'h2A5, 2);
    doRead(2'd0, 10'h2A5, 8'h01, "ram 2A5 set");
    doRead(2'd2, 10'h000, 8'h01, "summary set");
    doRead(2'd0, 10'h2A4, 8'h00, "ram 2A4 clear");

    // Clear then immediate read; then an edge coinciding with a clear still lands
    doWrite(2'd0, 10'h2A5);
    doRead(2'd0, 10'h2A5, 8'h00, "ram 2A5 after clear");
    alignEn();
    spr = 1'b1; sprAd = 10'h2A5;
    req = 1'b1; wr = 1'b1; sel = 2'd0; ad = 10'h2A5;
    applyStimulus();
    req = 1'b0; wr = 1'b0;
    applyStimulus();
    spr = 1'b0;
    repeat (3) applyStimulus();
    doRead(2'd0, 10'h2A5, 8'h01, "set beats clear");
    doWrite(2'd2, 10'h000);
    doRead(2'd2, 10'h000, 8'h00, "summary cleared");

    // CPU hogs the RAM port while six edges arrive: four queued, overflow flagged
    req = 1'b1; wr = 1'b0; sel = 2'd0; ad = 10'h100;
    alignEn();
    for (int e = 0; e < 6; e++) begin
      for (int c = 0; c < 4; c++) begin
        req = 1'b1; wr = 1'b0; sel = 2'd0; ad = evAd[(e + c) % 6];
        spr = (c < 2); sprAd = evAd[e];
        applyStimulus();
      end
    end
    req = 1'b0; spr = 1'b0;
    checkOutput("ovf after six edges", {7'b0, ovf}, 8'h01);
    repeat (6) applyStimulus();
    for (int e = 0; e < 6; e++)
      doRead(2'd0, evAd[e], (e < 4) ? 8'h01 : 8'h00, $sformatf("overflow event %0d", e));
    doRead(2'd2, 10'h000, 8'h01, "summary after drain");

    // Background register set, clear and the unmapped select
    alignEn();
    bg = 1'b1; bgAd = 5'd31;
    repeat (2) applyStimulus();
    bg = 1'b0;
    repeat (2) applyStimulus();
    doRead(2'd1, 10'd31, 8'h01, "bg 31 set");
    doRead(2'd1, 10'd30, 8'h00, "bg 30 clear");
    doWrite(2'd1, 10'd31);
    doRead(2'd1, 10'd31, 8'h00, "bg 31 cleared");
    doRead(2'd3, 10'h2A5, 8'h00, "unmapped read");

    // Reset mid-sweep with a read in flight
    rstN = 1'b0;
    applyStimulus();
    rstN = 1'b1;
    repeat (500) applyStimulus();
    req = 1'b1; wr = 1'b0; sel = 2'd2; ad = 10'h000;
    applyStimulus();
    req = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("mid-sweep reset busy", {7'b0, busy}, 8'h01);
    checkOutput("mid-sweep reset ovf", {7'b0, ovf}, 8'h00);
    checkOutput("mid-sweep reset dval", {7'b0, dval}, 8'h00);
    repeat (2) applyStimulus();
    checkOutput("cancelled read dval", {7'b0, dval}, 8'h00);
    rstN = 1'b1;
    repeat (1023) applyStimulus();
    checkOutput("restart busy at 1023", {7'b0, busy}, 8'h01);
    applyStimulus();
    checkOutput("restart busy done", {7'b0, busy}, 8'h00);
    doRead(2'd0, 10'h2A5, 8'h00, "ram cleared by resweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
